// File: rtl/ras_predictor_if.sv
// ras_predictor_if: fetch-side request and prediction bundle for ras_predictor
interface ras_predictor_if #(
  parameter int ADDR_W = 48,
  parameter int DEPTH = 8,
  parameter int NCKPT = 4
);
  logic instr_valid;
  logic [ADDR_W-1:0] pc;
  logic [31:0] instr;
  logic flush;
  logic ckpt_save;
  logic [$clog2(NCKPT)-1:0] ckpt_id;
  logic restore;
  logic [$clog2(NCKPT)-1:0] restore_id;
  logic pred_valid;
  logic [ADDR_W-1:0] pred_pc;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  modport master (
    output instr_valid, pc, instr, flush, ckpt_save, ckpt_id, restore, restore_id,
    input pred_valid, pred_pc, count, overflow
  );
  modport slave (
    input instr_valid, pc, instr, flush, ckpt_save, ckpt_id, restore, restore_id,
    output pred_valid, pred_pc, count, overflow
  );
endinterface

// File: rtl/ras_predictor.sv
// ras_predictor: circular return address stack with flush and checkpoint/restore (slots built only with RAS_CKPT_EN)
module ras_predictor #(
  parameter int ADDR_W = 48,
  parameter int DEPTH = 8,
  parameter int NCKPT = 4
) (
  input logic clk,
  input logic reset,
  ras_predictor_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPL} op_e;
  logic [ADDR_W-1:0] stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_up;
  logic [PW:0] cnt;
  logic ovf;
  op_e op;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic rd_link;
  logic rs1_link;
  logic is_jal;
  logic is_jalr;
  logic empty;
  logic full;
  logic do_push;
  logic do_pop;
  logic do_repl;
  logic drop;
  logic [ADDR_W-1:0] link_pc;
  logic load_ckpt;
  logic [PW-1:0] ld_ptr;
  logic [PW:0] ld_cnt;
  logic [ADDR_W-1:0] ld_top;
  logic unused_bits;
  assign unused_bits = ^bus.instr[31:20];
  // decode the instruction into a stack operation and drive the prediction
  always_comb begin
    rd = bus.instr[11:7];
    rs1 = bus.instr[19:15];
    rd_link = rd == 5'd1 || rd == 5'd5;
    rs1_link = rs1 == 5'd1 || rs1 == 5'd5;
    is_jal = bus.instr[6:0] == 7'h6f;
    is_jalr = bus.instr[6:0] == 7'h67 && bus.instr[14:12] == 3'd0;
    op = !bus.instr_valid ? OP_NONE :
         is_jal ? (rd_link ? OP_PUSH : OP_NONE) :
         !is_jalr ? OP_NONE :
         rd_link ? ((rs1_link && rd != rs1) ? OP_REPL : OP_PUSH) :
         rs1_link ? OP_POP : OP_NONE;
    empty = cnt == '0;
    full = cnt == (PW+1)'(DEPTH);
    do_pop = op == OP_POP && !empty;
    do_repl = op == OP_REPL && !empty;
    do_push = op == OP_PUSH || (op == OP_REPL && empty);
    link_pc = bus.pc + ADDR_W'(4);
    ptr_up = ptr + PW'(1);
    drop = bus.flush || (bus.restore && !load_ckpt);
    bus.pred_valid = !reset && (do_pop || do_repl);
    bus.pred_pc = bus.pred_valid ? stack[ptr] : '0;
    bus.count = cnt;
    bus.overflow = ovf;
  end
`ifdef RAS_CKPT_EN
  typedef struct packed {
    logic valid;
    logic [PW-1:0] ptr;
    logic [PW:0] cnt;
    logic [ADDR_W-1:0] top;
  } ckpt_t;
  ckpt_t slots [NCKPT];
  ckpt_t rd_slot;
  // select the restore slot; an invalid slot falls back to an empty stack
  always_comb begin
    rd_slot = slots[bus.restore_id];
    load_ckpt = bus.restore && rd_slot.valid;
    ld_ptr = rd_slot.ptr;
    ld_cnt = rd_slot.cnt;
    ld_top = rd_slot.top;
  end
  // snapshot pre-update pointer, count and top entry when no flush/restore competes
  always_ff @(posedge clk) begin
    if (reset)
      for (int i = 0; i < NCKPT; i++) slots[i] <= '0;
    else if (bus.ckpt_save && !bus.flush && !bus.restore)
      slots[bus.ckpt_id] <= '{valid: 1'b1, ptr: ptr, cnt: cnt, top: stack[ptr]};
  end
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{bus.ckpt_save, bus.ckpt_id, bus.restore_id, NCKPT == 0};
  assign load_ckpt = 1'b0;
  assign ld_ptr = '0;
  assign ld_cnt = '0;
  assign ld_top = '0;
`endif
  // stack state: reset > flush/invalid restore > restore > push/pop/replace
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (drop) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (bus.restore) begin
      ptr <= ld_ptr;
      cnt <= ld_cnt;
      stack[ld_ptr] <= ld_top;
    end else if (do_push) begin
      ptr <= ptr_up;
      stack[ptr_up] <= link_pc;
      cnt <= full ? cnt : cnt + (PW+1)'(1);
      ovf <= ovf | full;
    end else if (do_pop) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end else if (do_repl) begin
      stack[ptr] <= link_pc;
    end
  end
endmodule

// File: tb/tb_ras_predictor.sv
// tb_ras_predictor: directed and random stimulus against a queue-of-addresses style reference model
module tb_ras_predictor;
  localparam int AW = 48;
  localparam int D = 8;
  localparam int NC = 4;
`ifdef RAS_CKPT_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  ras_predictor_if #(.ADDR_W(AW), .DEPTH(D), .NCKPT(NC)) bus();
  ras_predictor #(.ADDR_W(AW), .DEPTH(D), .NCKPT(NC)) dut (.clk(clk), .reset(reset), .bus(bus));
  // free-running clock
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic [AW-1:0] mem [D];
  int sp;
  int n;
  bit ovf;
  bit cv [NC];
  int csp [NC];
  int cn [NC];
  logic [AW-1:0] ctop [NC];
  logic obs_pv;
  logic [AW-1:0] obs_pp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'h0, rd, 7'h6f};
  endfunction

  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [2:0] f3);
    return {12'h0, rs1, f3, rd, 7'h67};
  endfunction

  // 0 none, 1 push, 2 pop, 3 replace
  function automatic int kind(input logic [31:0] i);
    bit rdl;
    bit rsl;
    rdl = i[11:7] == 5'd1 || i[11:7] == 5'd5;
    rsl = i[19:15] == 5'd1 || i[19:15] == 5'd5;
    if (i[6:0] == 7'h6f) return rdl ? 1 : 0;
    if (i[6:0] != 7'h67 || i[14:12] != 3'd0) return 0;
    if (!rdl) return rsl ? 2 : 0;
    return (rsl && i[11:7] != i[19:15]) ? 3 : 1;
  endfunction

  task automatic cycle();
    int k;
    logic epv;
    logic [AW-1:0] epp;
    int id;
    int rid;
    @(negedge clk);
    k = bus.instr_valid ? kind(bus.instr) : 0;
    epv = !reset && (k == 2 || k == 3) && n > 0;
    epp = epv ? mem[(sp + D - 1) % D] : '0;
    obs_pv = bus.pred_valid;
    obs_pp = bus.pred_pc;
    chk("pred_valid", obs_pv, epv);
    chk("pred_pc", obs_pp, epp);
    chk("count", bus.count, n);
    chk("overflow", bus.overflow, ovf);
    @(posedge clk);
    id = bus.ckpt_id;
    rid = bus.restore_id;
    if (reset) begin
      foreach (mem[j]) mem[j] = '0;
      foreach (cv[j]) cv[j] = 1'b0;
      sp = 0;
      n = 0;
      ovf = 1'b0;
    end else begin
      if (CK && bus.ckpt_save && !bus.flush && !bus.restore) begin
        cv[id] = 1'b1;
        csp[id] = sp;
        cn[id] = n;
        ctop[id] = mem[(sp + D - 1) % D];
      end
      if (bus.flush || (bus.restore && !(CK && cv[rid]))) begin
        sp = 0;
        n = 0;
        ovf = 1'b0;
      end else if (bus.restore) begin
        sp = csp[rid];
        n = cn[rid];
        mem[(sp + D - 1) % D] = ctop[rid];
      end else if (k == 1 || (k == 3 && n == 0)) begin
        mem[sp] = bus.pc + 4;
        sp = (sp + 1) % D;
        if (n == D) ovf = 1'b1;
        else n++;
      end else if (k == 2 && n > 0) begin
        sp = (sp + D - 1) % D;
        n--;
      end else if (k == 3) begin
        mem[(sp + D - 1) % D] = bus.pc + 4;
      end
    end
    #1;
  endtask

  task automatic clr();
    bus.instr_valid = 1'b0;
    bus.pc = '0;
    bus.instr = 32'h13;
    bus.flush = 1'b0;
    bus.ckpt_save = 1'b0;
    bus.ckpt_id = '0;
    bus.restore = 1'b0;
    bus.restore_id = '0;
    reset = 1'b0;
  endtask

  task automatic ins(input logic [AW-1:0] p, input logic [31:0] i);
    clr();
    bus.instr_valid = 1'b1;
    bus.pc = p;
    bus.instr = i;
    cycle();
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom % 4;
    return r == 0 ? 5'd0 : r == 1 ? 5'd1 : r == 2 ? 5'd5 : 5'($urandom % 32);
  endfunction

  // directed scenarios, then randomized traffic
  initial begin
    sp = 0;
    n = 0;
    ovf = 1'b0;
    foreach (mem[j]) mem[j] = '0;
    foreach (cv[j]) cv[j] = 1'b0;
    clr();
    reset = 1'b1;
    cycle();
    cycle();
    clr();
    cycle();
    chk("rst_count", bus.count, 0);
    chk("rst_ovf", bus.overflow, 0);
    ins(48'h1000, jal(5'd1));
    chk("pp_cnt1", bus.count, 1);
    ins(48'h1010, jalr(5'd0, 5'd1, 3'd0));
    chk("pp_pv", obs_pv, 1);
    chk("pp_pc", obs_pp, 48'h1004);
    chk("pp_cnt0", bus.count, 0);
    for (int i = 0; i < 9; i++) ins(48'(i * 16), jal(5'd1));
    chk("ov_flag", bus.overflow, 1);
    chk("ov_cnt", bus.count, 8);
    for (int i = 0; i < 8; i++) begin
      ins(48'h2000, jalr(5'd0, 5'd1, 3'd0));
      chk("ov_pop", obs_pp, 48'h84 - 48'(i * 16));
    end
    ins(48'h2000, jalr(5'd0, 5'd1, 3'd0));
    chk("ov_empty", obs_pv, 0);
    ins(48'h50, jal(5'd1));
    clr();
    bus.ckpt_save = 1'b1;
    bus.ckpt_id = 2'd1;
    cycle();
    clr();
    bus.flush = 1'b1;
    bus.restore = 1'b1;
    bus.restore_id = 2'd1;
    bus.instr_valid = 1'b1;
    bus.pc = 48'h60;
    bus.instr = jal(5'd1);
    cycle();
    chk("pr_cnt", bus.count, 0);
    chk("pr_ovf", bus.overflow, 0);
    ins(48'h70, jalr(5'd0, 5'd1, 3'd0));
    chk("pr_pv", obs_pv, 0);
    ins(48'h200, jal(5'd1));
    ins(48'h300, jalr(5'd5, 5'd1, 3'd0));
    chk("rp_pv", obs_pv, 1);
    chk("rp_pc", obs_pp, 48'h204);
    chk("rp_cnt", bus.count, 1);
    ins(48'h310, jalr(5'd0, 5'd1, 3'd0));
    chk("rp_top", obs_pp, 48'h304);
    clr();
    bus.flush = 1'b1;
    cycle();
    ins(48'h100, jal(5'd1));
    clr();
    bus.ckpt_save = 1'b1;
    bus.ckpt_id = 2'd2;
    cycle();
    ins(48'h500, jal(5'd1));
    ins(48'h510, jalr(5'd0, 5'd1, 3'd0));
    ins(48'h600, jal(5'd1));
    clr();
    bus.restore = 1'b1;
    bus.restore_id = 2'd2;
    cycle();
    ins(48'h700, jalr(5'd0, 5'd1, 3'd0));
    chk("ck_pv", obs_pv, CK);
    chk("ck_pc", obs_pp, CK ? 48'h104 : 48'h0);
    chk("ck_cnt", bus.count, 0);
    for (int i = 0; i < 3; i++) ins(48'(32'h800 + i * 16), jal(5'd1));
    clr();
    reset = 1'b1;
    bus.instr_valid = 1'b1;
    bus.pc = 48'h840;
    bus.instr = jalr(5'd0, 5'd1, 3'd0);
    cycle();
    chk("rm_pv", obs_pv, 0);
    chk("rm_cnt", bus.count, 0);
    ins(48'h900, jal(5'd1));
    clr();
    bus.restore = 1'b1;
    bus.restore_id = 2'd2;
    cycle();
    chk("rm_rst_cnt", bus.count, 0);
    ins(48'h910, jalr(5'd0, 5'd1, 3'd0));
    chk("rm_rst_pv", obs_pv, 0);
    for (int c = 0; c < 3000; c++) begin
      int r;
      clr();
      r = $urandom % 8;
      bus.instr_valid = ($urandom % 8) != 0;
      bus.pc = {16'($urandom), 32'($urandom)};
      bus.instr = r < 3 ? jal(pick_reg()) :
                  r < 7 ? jalr(pick_reg(), pick_reg(), ($urandom % 6 == 0) ? 3'($urandom) : 3'd0) :
                  32'($urandom);
      bus.flush = ($urandom % 30) == 0;
      bus.restore = ($urandom % 20) == 0;
      bus.restore_id = 2'($urandom);
      bus.ckpt_save = ($urandom % 8) == 0;
      bus.ckpt_id = 2'($urandom);
      reset = ($urandom % 200) == 0;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ras_predictor.md
RAS_PREDICTOR -- requirements
Module: ras_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 48: PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: stack entries, power of two, at least 2.
REQ-003 SHALL have parameter NCKPT, default 4: checkpoint slots, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port instr_valid, input, 1 bit: pc/instr qualify this cycle.
REQ-007 SHALL have port pc, input, ADDR_W bits: address of instr.
REQ-008 SHALL have port instr, input, 32 bits: fetched instruction word.
REQ-009 SHALL have port flush, input, 1 bit: empty the stack.
REQ-010 SHALL have port ckpt_save, input, 1 bit: snapshot state into slot ckpt_id.
REQ-011 SHALL have port ckpt_id, input, log2(NCKPT) bits: slot written by ckpt_save.
REQ-012 SHALL have port restore, input, 1 bit: reload state from slot restore_id.
REQ-013 SHALL have port restore_id, input, log2(NCKPT) bits: slot read by restore.
REQ-014 SHALL have port pred_valid, output, 1 bit: pred_pc holds a return target.
REQ-015 SHALL have port pred_pc, output, ADDR_W bits: predicted return address.
REQ-016 SHALL have port count, output, log2(DEPTH)+1 bits: number of valid entries.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag; an entry was overwritten.

Function
REQ-018 SHALL treat x1 and x5 as link registers; act only when instr_valid=1.
REQ-019 SHALL decode JAL (opcode 0x6f) with rd as a link register as push.
REQ-020 SHALL decode JALR (opcode 0x67, funct3=0) as follows:
- rd !link, rs1 !link: none.
- rd !link, rs1 link: pop.
- rd link, rs1 !link: push.
- rd link, rs1 link, rd!=rs1: replace.
- rd link, rs1 link, rd==rs1: push.
REQ-021 SHALL take no action for JALR with funct3 non-zero, or for any other opcode.
REQ-022 SHALL push pc+4, computed modulo 2^ADDR_W.
REQ-023 SHALL store entries in a circular buffer with a top-of-stack pointer that wraps modulo DEPTH.
REQ-024 SHALL drive, combinationally in the same cycle as a pop or replace with count>0: pred_valid=1 and pred_pc=top entry; otherwise pred_valid=0 and pred_pc=0.
REQ-025 SHALL, on a pop with count>0, decrement the pointer and count at the clock edge.
REQ-026 SHALL treat a pop with count=0 as no action and drive pred_valid=0.
REQ-027 SHALL, on a push with count=DEPTH, overwrite the oldest entry, hold count at DEPTH and set overflow.
REQ-028 SHALL, on replace with count>0, overwrite the top entry with pc+4 and leave count unchanged.
REQ-029 SHALL treat replace with count=0 as a push.
REQ-030 SHALL make ckpt_save capture {pointer, count, top entry} as they were before this cycle's update.
REQ-031 SHALL make restore load pointer, count and top entry from the slot at the next edge; deeper entries are not restored.
REQ-032 SHALL apply the priority flush > restore > instruction update; the lower-priority action is dropped.
REQ-033 SHALL ignore ckpt_save in any cycle where flush or restore is asserted.
REQ-034 SHALL make flush set pointer=0, count=0 and clear overflow; checkpoint slots are unchanged.

Reset
REQ-035 SHALL, on reset, set pointer=0, count=0, overflow=0, all stack entries=0 and all checkpoint slots invalid.
REQ-036 SHALL make reset take priority over every other input.
REQ-037 SHALL hold pred_valid=0 and pred_pc=0 while reset=1.
REQ-038 SHALL treat restore from an invalid slot as a flush.

Configuration
REQ-039 SHALL, with macro RAS_CKPT_EN defined, implement the checkpoint slots and restore as specified.
REQ-040 SHALL, without RAS_CKPT_EN, omit the checkpoint storage, ignore ckpt_save, behave as flush on restore, and keep all ports present.

Verification
REQ-041 SHALL test push then pop: JAL x1 at pc=0x1000, then JALR x0,0(x1) -> pred_valid=1, pred_pc=0x1004, count 1 then 0.
REQ-042 SHALL test overflow: DEPTH+1=9 pushes at pc=0x0,0x10..0x80, then 8 pops -> overflow=1, count=8, pops return 0x84..0x14; a 9th pop gives pred_valid=0.
REQ-043 SHALL test replace: push at pc=0x200, then JALR x5,0(x1) at pc=0x300 -> pred_pc=0x204, top becomes 0x304, count=1.
REQ-044 SHALL test checkpoint: with stack holding 0x104, save slot 2, push at 0x500, pop, push at 0x600, restore slot 2, then pop -> pred_pc=0x104 and count=0 afterwards.
REQ-045 SHALL test priority: flush, restore and push in the same cycle -> count=0, overflow=0; a following pop gives pred_valid=0.
REQ-046 SHALL test reset mid-operation: 3 pushes, then reset=1 for one cycle alongside a pop -> pred_valid=0, count=0; afterwards restore of any slot behaves as a flush.
